// File: rtl/serial_add_sequencer_if.sv
// Handshake and slice bus for serial_add_sequencer: operand/result handshakes
// plus the 2-bit adder slice connection.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             startValid;
  logic             startReady;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             carryIn;
  logic [1:0]       sliceA;
  logic [1:0]       sliceB;
  logic             sliceCin;
  logic [1:0]       sliceSum;
  logic             sliceCout;
  logic [WIDTH-1:0] result;
  logic             carryOut;
  logic             resultValid;
  logic             resultReady;

  modport slave (
    input  startValid, opA, opB, carryIn, sliceSum, sliceCout, resultReady,
    output startReady, sliceA, sliceB, sliceCin, result, carryOut, resultValid
  );

  modport master (
    output startValid, opA, opB, carryIn, sliceSum, sliceCout, resultReady,
    input  startReady, sliceA, sliceB, sliceCin, result, carryOut, resultValid
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Multi-cycle WIDTH-bit adder that time-shares one external combinational
// 2-bit adder slice, retiring two sum bits per clock (LSBs first).
module serial_add_sequencer #(
  parameter int WIDTH = 8  // even, >= 2
) (
  input  logic                 clk,
  input  logic                 rstN,
  serial_add_sequencer_if.slave bus
);

  localparam int BEATS = WIDTH / 2;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] beat;
  logic [WIDTH-1:0] sum_next;
  logic             accept;
  logic             last_beat;

  assign accept    = (state == IDLE) && bus.startValid;
  assign last_beat = (beat == LAST_BEAT);

  // New slice sum enters at the top; after BEATS shifts the LSB pair is at bit 0.
  assign sum_next = WIDTH'({bus.sliceSum, sum_reg} >> 2);

  // Result holds its last value in IDLE; only meaningful while resultValid.
  assign bus.result   = sum_reg;
  assign bus.carryOut = carry_reg;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.startReady  = 1'b0;
    bus.resultValid = 1'b0;
    bus.sliceA      = 2'b00;
    bus.sliceB      = 2'b00;
    bus.sliceCin    = 1'b0;
    case (state)
      IDLE: begin
        bus.startReady = 1'b1;
        if (bus.startValid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Slice inputs come from registers only, never from the start inputs.
        bus.sliceA   = a_reg[1:0];
        bus.sliceB   = b_reg[1:0];
        bus.sliceCin = carry_reg;
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.resultValid = 1'b1;
        if (bus.resultReady) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      beat      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= bus.opA;
            b_reg     <= bus.opB;
            carry_reg <= bus.carryIn;
            sum_reg   <= '0;
            beat      <= '0;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= bus.sliceCout;
          a_reg     <= a_reg >> 2;
          b_reg     <= b_reg >> 2;
          beat      <= beat + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: directed vectors, backpressure,
// mid-run reset and randomised operations against an arithmetic reference.
module tb_serial_add_sequencer;

  localparam int WIDTH = 8;
  localparam int BEATS = WIDTH / 2;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  serial_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  // Behavioural stand-in for the combinational twoBitAdder slice.
  assign {bus.sliceCout, bus.sliceSum} =
    {1'b0, bus.sliceA} + {1'b0, bus.sliceB} + {2'b00, bus.sliceCin};

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] res;
    logic             cout;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (!bus.startReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.startReady) begin
      check("accept_timeout", 0, 1);
      ok = 1'b0;
      return;
    end
    bus.startValid = 1'b1;
    bus.opA        = a;
    bus.opB        = b;
    bus.carryIn    = cin;
    @(posedge clk);
    @(negedge clk);
    bus.startValid = 1'b0;
  endtask

  // Follows one operation from its first RUN cycle through the result handshake.
  task automatic collect(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input int stall, input bit poke,
                         output logic [WIDTH-1:0] res, output logic cout);
    logic [WIDTH:0]   exp_sum;
    logic [WIDTH-1:0] held;
    int               n;
    exp_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    for (int i = 0; i < BEATS; i++) begin
      int mask;
      mask = (1 << (2 * i)) - 1;
      check($sformatf("sliceA[%0d]", i), int'(bus.sliceA), (int'(a) >> (2 * i)) & 3);
      check($sformatf("sliceB[%0d]", i), int'(bus.sliceB), (int'(b) >> (2 * i)) & 3);
      check($sformatf("sliceCin[%0d]", i), int'(bus.sliceCin),
            ((int'(a) & mask) + (int'(b) & mask) + int'(cin)) >> (2 * i));
      check("valid_during_run", int'(bus.resultValid), 0);
      if (poke) check("ready_during_run", int'(bus.startReady), 0);
      @(negedge clk);
    end
    check("latency_valid", int'(bus.resultValid), 1);
    n = 0;
    while (!bus.resultValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    res  = bus.result;
    cout = bus.carryOut;
    check("result", int'(res), int'(exp_sum[WIDTH-1:0]));
    check("carryOut", int'(cout), int'(exp_sum[WIDTH]));
    check("slices_zero_done", int'({bus.sliceA, bus.sliceB, bus.sliceCin}), 0);
    held = bus.result;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", int'(bus.resultValid), 1);
      check("hold_result", int'(bus.result), int'(held));
      check("hold_carry", int'(bus.carryOut), int'(cout));
      if (poke) check("ready_during_done", int'(bus.startReady), 0);
    end
    bus.resultReady = 1'b1;
    @(negedge clk);
    bus.resultReady = 1'b0;
    check("valid_drop", int'(bus.resultValid), 0);
    check("ready_idle", int'(bus.startReady), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] r;
    logic             c;
    bit               ok;

    vecs[0] = '{a: 8'h3C, b: 8'h0F, cin: 1'b0, res: 8'h4B, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, res: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, res: 8'hFF, cout: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, res: 8'h01, cout: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, res: 8'h00, cout: 1'b1};

    bus.startValid  = 1'b0;
    bus.opA         = '0;
    bus.opB         = '0;
    bus.carryIn     = 1'b0;
    bus.resultReady = 1'b0;
    rstN            = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_startReady", int'(bus.startReady), 1);
    check("rst_resultValid", int'(bus.resultValid), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_carryOut", int'(bus.carryOut), 0);
    check("rst_slices", int'({bus.sliceA, bus.sliceB, bus.sliceCin}), 0);
    rstN = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      accept(vecs[v].a, vecs[v].b, vecs[v].cin, ok);
      if (ok) begin
        collect(vecs[v].a, vecs[v].b, vecs[v].cin, 0, 1'b0, r, c);
        check($sformatf("vec%0d_result", v), int'(r), int'(vecs[v].res));
        check($sformatf("vec%0d_carry", v), int'(c), int'(vecs[v].cout));
      end
    end

    // Backpressure while a competing request is held on the start port.
    accept(8'h3C, 8'h0F, 1'b0, ok);
    if (ok) begin
      bus.startValid = 1'b1;
      bus.opA        = 8'hAA;
      bus.opB        = 8'h55;
      bus.carryIn    = 1'b1;
      collect(8'h3C, 8'h0F, 1'b0, 5, 1'b1, r, c);
      check("bp_result", int'(r), 8'h4B);
      @(posedge clk);
      @(negedge clk);
      bus.startValid = 1'b0;
      collect(8'hAA, 8'h55, 1'b1, 0, 1'b0, r, c);
      check("bp_next_result", int'(r), 8'h00);
      check("bp_next_carry", int'(c), 1);
    end

    // Reset in the middle of an operation.
    accept(8'hA5, 8'h5A, 1'b1, ok);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    check("midrst_startReady", int'(bus.startReady), 1);
    check("midrst_resultValid", int'(bus.resultValid), 0);
    check("midrst_result", int'(bus.result), 0);
    check("midrst_carryOut", int'(bus.carryOut), 0);
    accept(8'h12, 8'h34, 1'b0, ok);
    if (ok) begin
      collect(8'h12, 8'h34, 1'b0, 0, 1'b0, r, c);
      check("post_rst_result", int'(r), 8'h46);
      check("post_rst_carry", int'(c), 0);
    end

    for (int k = 0; k < 200; k++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      accept(ra, rb, rc, ok);
      if (ok) collect(ra, rb, rc, $urandom_range(0, 3), 1'b0, r, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
